// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding for the gated frequency counter
package freq_meter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with rising-edge detect on the synchronized level
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
      dly_q  <= sync_q[STAGES-1];
    end
  end
  assign q_sync = sync_q[STAGES-1];
  assign rise   = q_sync & ~dly_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a GATE_CYCLES window and latches the result
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  state_e           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d, freq_q, freq_d;
  logic             ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, valid_q, valid_d;
  logic             rise, sync_unused;
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_async(sig_in),
    .q_sync (sync_unused),
    .rise   (rise)
  );
  // Result registers load on entry to DONE so freq_valid and the new freq appear together
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    edge_d    = edge_q;
    ovf_acc_d = ovf_acc_q;
    freq_d    = freq_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    if (state_q == ST_GATE) begin
      if (!en) begin
        state_d = ST_IDLE;
      end else begin
        gate_d = gate_q + 1'b1;
        if (rise) begin
          edge_d    = &edge_q ? edge_q : edge_q + 1'b1;
          ovf_acc_d = ovf_acc_q | (&edge_q);
        end
        if (gate_q == LAST) begin
          state_d = ST_DONE;
          freq_d  = edge_d;
          ovf_d   = ovf_acc_d;
          valid_d = 1'b1;
        end
      end
    end else begin
      gate_d    = '0;
      edge_d    = '0;
      ovf_acc_d = 1'b0;
      state_d   = en ? ST_GATE : ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gate_q    <= '0;
      edge_q    <= '0;
      ovf_acc_q <= 1'b0;
      freq_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      ovf_acc_q <= ovf_acc_d;
      freq_q    <= freq_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end
  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = ovf_q;
  assign busy       = state_q == ST_GATE;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random and directed stimulus on 8-bit and 4-bit meters against a window-level model
module tb_freq_meter;
  localparam int G = 100;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, sig_in = 1'b0;
  logic [7:0] f8;
  logic [3:0] f4;
  logic       v8, v4, o8, o4, b8, b4;
  int         n_chk = 0, n_pass = 0, per = 0;
  always #5 clk = ~clk;
  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(f8), .freq_valid(v8), .overflow(o8), .busy(b8)
  );
  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(f4), .freq_valid(v4), .overflow(o4), .busy(b4)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  // Signal source: per==0 gives random bits, otherwise a square wave of per cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      sig_in = (per == 0) ? 1'($urandom) : ((ph % per) < per / 2);
    end
  end
  // Model: rises seen SYNC_STAGES+1 edges late, unbounded count per window, clamped at close
  int     ph_m[2], pos[2], cnt[2], mx;
  longint m_freq[2];
  bit     m_ovf[2], m_val[2], samp[3], rise_m;
  initial begin
    forever begin
      @(posedge clk);
      rise_m = samp[1] & ~samp[2];
      for (int k = 0; k < 2; k++) begin
        mx = (k == 0) ? 255 : 15;
        if (rst) begin
          ph_m[k] = 0; m_freq[k] = 0; m_ovf[k] = 0; m_val[k] = 0;
        end else begin
          m_val[k] = 0;
          if (ph_m[k] == 1) begin
            if (!en) ph_m[k] = 0;
            else begin
              cnt[k] += int'(rise_m);
              pos[k]++;
              if (pos[k] == G) begin
                m_freq[k] = (cnt[k] > mx) ? mx : cnt[k];
                m_ovf[k]  = cnt[k] > mx;
                m_val[k]  = 1;
                ph_m[k]   = 2;
              end
            end
          end else if (en) begin
            ph_m[k] = 1; pos[k] = 0; cnt[k] = 0;
          end else ph_m[k] = 0;
        end
      end
      if (rst) begin
        samp[0] = 0; samp[1] = 0; samp[2] = 0;
      end else begin
        samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = sig_in;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      chk("freq8", f8, m_freq[0]);
      chk("valid8", v8, m_val[0]);
      chk("ovf8", o8, m_ovf[0]);
      chk("busy8", b8, ph_m[0] == 1);
      chk("freq4", f4, m_freq[1]);
      chk("valid4", v4, m_val[1]);
      chk("ovf4", o4, m_ovf[1]);
      chk("busy4", b4, ph_m[1] == 1);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (v8) break;
    end
    chk("valid_seen", v8, 1);
  endtask
  initial begin
    int n, quiet;
    rst = 1; en = 0; per = 0;
    cyc(3);
    rst = 0;
    cyc(500);
    chk("idle_freq", f8, 0);
    chk("idle_valid", v8, 0);
    chk("idle_ovf", o8, 0);
    chk("idle_busy", b8, 0);
    per = 10; en = 1;
    wait_valid(300, n);
    for (int i = 0; i < 3; i++) begin
      wait_valid(300, n);
      chk("period101", n, 101);
      chk("p10_freq8", f8, 10);
      chk("p10_ovf8", o8, 0);
      chk("p10_freq4", f4, 10);
      chk("done_busy", b8, 0);
    end
    cyc(1);
    chk("busy_after_done", b8, 1);
    per = 2;
    wait_valid(300, n);
    wait_valid(300, n);
    chk("p2_freq8", f8, 50);
    chk("p2_ovf8", o8, 0);
    chk("p2_freq4", f4, 15);
    chk("p2_ovf4", o4, 1);
    per = 3;
    wait_valid(300, n);
    for (int i = 0; i < 2; i++) begin
      wait_valid(300, n);
      chk("p3_freq8_33_34", (f8 == 8'd33) || (f8 == 8'd34), 1);
    end
    per = 4;
    wait_valid(300, n);
    wait_valid(300, n);
    chk("p4_freq4", f4, 15);
    chk("p4_ovf4", o4, 1);
    chk("p4_freq8", f8, 25);
    chk("p4_ovf8", o8, 0);
    per = 10;
    wait_valid(300, n);
    wait_valid(300, n);
    chk("p10_freq4", f4, 10);
    chk("p10_ovf4", o4, 0);
    wait_valid(300, n);
    chk("pre_abort_freq", f8, 10);
    cyc(51);
    en = 0;
    cyc(1);
    chk("abort_busy", b8, 0);
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (v8) quiet++;
    end
    chk("abort_novalid", quiet, 0);
    chk("abort_freq_kept", f8, 10);
    en = 1;
    wait_valid(300, n);
    chk("pre_rst_freq", f8, 10);
    cyc(30);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("rst_freq", f8, 0);
    chk("rst_ovf", o8, 0);
    chk("rst_busy", b8, 0);
    chk("rst_valid", v8, 0);
    wait_valid(110, n);
    chk("restart_freq", (f8 == 8'd10) || (f8 == 8'd11), 1);
    for (int i = 0; i < 40; i++) begin
      per = $urandom_range(0, 12);
      if (per == 1) per = 2;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1;
        cyc(1);
        rst = 0;
      end
      cyc($urandom_range(20, 300));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
